flush_sequencer: RTL and testbench

- Parametrised cache-flush coordinator for the core/L1/L2 top level.
- Accepts flush requests from any of N_L1 first-level caches and tracks per-cache completion.
- Once every requested L1 has drained, issues a single L2 flush (or skips it in L1-only mode), then reports completion.
- Adds three capabilities to the fixed two-cache flush FSM: requests that join an in-progress flush, queued re-flush, and a watchdog timeout with sticky error.

---
 rtl/flush_sequencer.sv | 155 +++++++++++++++
 tb/tb_flush_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flush_sequencer.sv
// Cache-flush coordinator: gathers per-L1 flush completions, then issues one L2 flush.
// Supports late-joining requests, queued re-flush during the L2 phase and a watchdog abort.
module flush_sequencer #(
    parameter int unsigned N_L1      = 2,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_L1-1:0]      l1_flush_req,
    input  logic [N_L1-1:0]      l1_flush_complete,
    input  logic                 l2_flush_complete,
    input  logic                 skip_l2,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 err_clear,
    output logic                 in_flush_mode,
    output logic                 l2_flush_req,
    output logic                 flush_done,
    output logic [N_L1-1:0]      pending_mask,
    output logic                 timeout_err,
    output logic [31:0]          flush_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_L1 = 2'd1,
        WAIT_L2 = 2'd2
    } state_t;

    state_t               state;
    logic [N_L1-1:0]      pending;
    logic [N_L1-1:0]      deferred;
    logic                 l2_skip_r;
    logic [TIMEOUT_W-1:0] wd_cnt;

    logic [N_L1-1:0]      pending_nxt;
    logic [N_L1-1:0]      deferred_nxt;
    logic                 l1_progress;
    logic                 wd_fire;
    logic [TIMEOUT_W-1:0] wd_limit;
    logic [TIMEOUT_W-1:0] wd_inc;

    always_comb begin
        // A request and a completion on the same bit leave it owed
        pending_nxt  = (pending & ~l1_flush_complete) | l1_flush_req;
        deferred_nxt = deferred | l1_flush_req;
        l1_progress  = |(pending & l1_flush_complete);
        wd_limit     = timeout_cycles - TIMEOUT_W'(1);
        wd_fire      = (timeout_cycles != '0) && (wd_cnt == wd_limit);
        wd_inc       = (wd_cnt == '1) ? wd_cnt : wd_cnt + TIMEOUT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            deferred      <= '0;
            l2_skip_r     <= 1'b0;
            wd_cnt        <= '0;
            in_flush_mode <= 1'b0;
            l2_flush_req  <= 1'b0;
            flush_done    <= 1'b0;
            pending_mask  <= '0;
            timeout_err   <= 1'b0;
            flush_count   <= '0;
        end else begin
            l2_flush_req <= 1'b0;
            flush_done   <= 1'b0;
            // A timeout raised below overrides this clear
            if (err_clear) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|l1_flush_req) begin
                        state         <= WAIT_L1;
                        pending       <= l1_flush_req;
                        pending_mask  <= l1_flush_req;
                        in_flush_mode <= 1'b1;
                        l2_skip_r     <= skip_l2;
                        wd_cnt        <= '0;
                    end
                end

                WAIT_L1: begin
                    if (pending_nxt == '0) begin
                        pending      <= '0;
                        pending_mask <= '0;
                        wd_cnt       <= '0;
                        // Nothing can be deferred while waiting on L1s, so skip mode always ends here
                        if (l2_skip_r) begin
                            flush_done    <= 1'b1;
                            flush_count   <= flush_count + 32'd1;
                            in_flush_mode <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            l2_flush_req <= 1'b1;
                            state        <= WAIT_L2;
                        end
                    end else if (l1_progress) begin
                        pending      <= pending_nxt;
                        pending_mask <= pending_nxt;
                        wd_cnt       <= '0;
                    end else if (wd_fire) begin
                        timeout_err   <= 1'b1;
                        pending       <= '0;
                        pending_mask  <= '0;
                        deferred      <= '0;
                        in_flush_mode <= 1'b0;
                        wd_cnt        <= '0;
                        state         <= IDLE;
                    end else begin
                        pending      <= pending_nxt;
                        pending_mask <= pending_nxt;
                        wd_cnt       <= wd_inc;
                    end
                end

                WAIT_L2: begin
                    if (l2_flush_complete) begin
                        flush_done  <= 1'b1;
                        flush_count <= flush_count + 32'd1;
                        wd_cnt      <= '0;
                        deferred    <= '0;
                        if (deferred_nxt != '0) begin
                            pending      <= deferred_nxt;
                            pending_mask <= deferred_nxt;
                            l2_skip_r    <= skip_l2;
                            state        <= WAIT_L1;
                        end else begin
                            in_flush_mode <= 1'b0;
                            state         <= IDLE;
                        end
                    end else if (wd_fire) begin
                        timeout_err   <= 1'b1;
                        pending       <= '0;
                        pending_mask  <= '0;
                        deferred      <= '0;
                        in_flush_mode <= 1'b0;
                        wd_cnt        <= '0;
                        state         <= IDLE;
                    end else begin
                        deferred <= deferred_nxt;
                        wd_cnt   <= wd_inc;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flush_sequencer.sv
// Bench for flush_sequencer (N_L1=4): fixed vector table, directed corner sequences,
// and randomized traffic against a set-based reference model.
module tb_flush_sequencer;

    logic        clk;
    logic        reset;
    logic [3:0]  l1_flush_req;
    logic [3:0]  l1_flush_complete;
    logic        l2_flush_complete;
    logic        skip_l2;
    logic [15:0] timeout_cycles;
    logic        err_clear;
    logic        in_flush_mode;
    logic        l2_flush_req;
    logic        flush_done;
    logic [3:0]  pending_mask;
    logic        timeout_err;
    logic [31:0] flush_count;

    flush_sequencer #(.N_L1(4), .TIMEOUT_W(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .l1_flush_req      (l1_flush_req),
        .l1_flush_complete (l1_flush_complete),
        .l2_flush_complete (l2_flush_complete),
        .skip_l2           (skip_l2),
        .timeout_cycles    (timeout_cycles),
        .err_clear         (err_clear),
        .in_flush_mode     (in_flush_mode),
        .l2_flush_req      (l2_flush_req),
        .flush_done        (flush_done),
        .pending_mask      (pending_mask),
        .timeout_err       (timeout_err),
        .flush_count       (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a sequence is "active"; it owes a set of L1s, then (optionally) one L2.
    logic        m_active, m_l2wait, m_skip, m_err, m_l2r, m_done;
    logic [3:0]  m_owed, m_queued;
    int unsigned m_quiet;
    logic [31:0] m_count;

    function automatic void model_reset();
        m_active = 1'b0; m_l2wait = 1'b0; m_skip = 1'b0; m_err = 1'b0;
        m_l2r = 1'b0; m_done = 1'b0; m_owed = '0; m_queued = '0;
        m_quiet = 0; m_count = '0;
    endfunction

    function automatic void model_end_seq(input logic skp);
        m_done  = 1'b1;
        m_count = m_count + 32'd1;
        m_quiet = 0;
        if (m_queued != 4'b0) begin
            m_owed   = m_queued;
            m_queued = '0;
            m_l2wait = 1'b0;
            m_skip   = skp;
        end else begin
            m_active = 1'b0;
        end
    endfunction

    function automatic void model_abort();
        m_err = 1'b1; m_active = 1'b0; m_owed = '0; m_queued = '0; m_l2wait = 1'b0; m_quiet = 0;
    endfunction

    function automatic void model_tick();
        if (m_quiet < 65535) m_quiet++;
    endfunction

    function automatic void model_step(input logic [3:0] req, input logic [3:0] l1c, input logic l2c,
                                       input logic skp, input logic eclr, input logic [15:0] tmo);
        logic [3:0] left;
        logic       stuck;
        m_l2r = 1'b0;
        m_done = 1'b0;
        if (eclr) m_err = 1'b0;
        stuck = (tmo != 16'd0) && (m_quiet == int'(tmo) - 1);
        if (!m_active) begin
            if (req != 4'b0) begin
                m_active = 1'b1; m_l2wait = 1'b0; m_owed = req; m_skip = skp; m_quiet = 0;
            end
        end else if (!m_l2wait) begin
            left = (m_owed & ~l1c) | req;
            if (left == 4'b0) begin
                m_owed = '0;
                m_quiet = 0;
                if (m_skip) model_end_seq(skp);
                else begin
                    m_l2r = 1'b1;
                    m_l2wait = 1'b1;
                end
            end else if ((m_owed & l1c) != 4'b0) begin
                m_owed = left;
                m_quiet = 0;
            end else if (stuck) begin
                model_abort();
            end else begin
                m_owed = left;
                model_tick();
            end
        end else begin
            if (l2c) begin
                m_queued = m_queued | req;
                model_end_seq(skp);
            end else if (stuck) begin
                model_abort();
            end else begin
                m_queued = m_queued | req;
                model_tick();
            end
        end
    endfunction

    function automatic logic [39:0] model_vec();
        return {m_active, m_l2r, m_done, m_err, (m_active && !m_l2wait) ? m_owed : 4'b0, m_count};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {in_flush_mode, l2_flush_req, flush_done, timeout_err, pending_mask, flush_count};
    endfunction

    function automatic void chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (ifm,l2r,done,err,pm,count)", name, act, exp);
    endfunction

    function automatic void chk_model(input string name);
        chk(name, dut_vec(), model_vec());
    endfunction

    task automatic step(input logic [3:0] req, input logic [3:0] l1c, input logic l2c, input logic eclr);
        l1_flush_req      = req;
        l1_flush_complete = l1c;
        l2_flush_complete = l2c;
        err_clear         = eclr;
        @(posedge clk);
        model_step(req, l1c, l2c, skip_l2, eclr, timeout_cycles);
        @(negedge clk);
        l1_flush_req      = '0;
        l1_flush_complete = '0;
        l2_flush_complete = 1'b0;
        err_clear         = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  l1c;
        logic        l2c;
        logic        skp;
        logic        ifm;
        logic        l2r;
        logic        done;
        logic [3:0]  pm;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] req, input logic [3:0] l1c, input logic l2c, input logic skp,
                                input logic ifm, input logic l2r, input logic done, input logic [3:0] pm,
                                input logic [31:0] cnt);
        vec_t v;
        v.req = req; v.l1c = l1c; v.l2c = l2c; v.skp = skp;
        v.ifm = ifm; v.l2r = l2r; v.done = done; v.pm = pm; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [3:0]  r, c;
        logic        l2c, ec;
        logic [31:0] base;
        logic [15:0] tmo_opts [4];

        // basic two-cache flush, timeout disabled
        add(4'b0011, 4'b0000, 0, 0,  1, 0, 0, 4'b0011, 32'd0);
        add(4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b0011, 32'd0);
        add(4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b0011, 32'd0);
        add(4'b0000, 4'b0001, 0, 0,  1, 0, 0, 4'b0010, 32'd0);
        add(4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b0010, 32'd0);
        add(4'b0000, 4'b0010, 0, 0,  1, 1, 0, 4'b0000, 32'd0);
        add(4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b0000, 32'd0);
        add(4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b0000, 32'd0);
        add(4'b0000, 4'b0000, 0, 0,  1, 0, 0, 4'b0000, 32'd0);
        add(4'b0000, 4'b0000, 1, 0,  0, 0, 1, 4'b0000, 32'd1);
        add(4'b0000, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 32'd1);
        // L1-only mode, skip_l2 dropped mid-sequence
        add(4'b0001, 4'b0000, 0, 1,  1, 0, 0, 4'b0001, 32'd1);
        add(4'b0000, 4'b0001, 0, 0,  0, 0, 1, 4'b0000, 32'd2);
        add(4'b0000, 4'b0000, 0, 0,  0, 0, 0, 4'b0000, 32'd2);
        // same-cycle req+complete keeps the bit; req during L2-complete cycle re-flushes
        add(4'b0100, 4'b0000, 0, 0,  1, 0, 0, 4'b0100, 32'd2);
        add(4'b0100, 4'b0100, 0, 0,  1, 0, 0, 4'b0100, 32'd2);
        add(4'b0000, 4'b0100, 0, 0,  1, 1, 0, 4'b0000, 32'd2);
        add(4'b0010, 4'b0000, 1, 0,  1, 0, 1, 4'b0010, 32'd3);
        add(4'b0000, 4'b0010, 0, 0,  1, 1, 0, 4'b0000, 32'd3);
        add(4'b0000, 4'b0000, 1, 0,  0, 0, 1, 4'b0000, 32'd4);
        // completions ignored in IDLE
        add(4'b0000, 4'b1111, 1, 0,  0, 0, 0, 4'b0000, 32'd4);

        reset = 1'b1;
        l1_flush_req = '0; l1_flush_complete = '0; l2_flush_complete = 1'b0;
        skip_l2 = 1'b0; timeout_cycles = '0; err_clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", dut_vec(), 40'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_idle", dut_vec(), 40'd0);

        foreach (tbl[i]) begin
            skip_l2 = tbl[i].skp;
            step(tbl[i].req, tbl[i].l1c, tbl[i].l2c, 1'b0);
            chk($sformatf("table[%0d]", i), dut_vec(),
                {tbl[i].ifm, tbl[i].l2r, tbl[i].done, 1'b0, tbl[i].pm, tbl[i].cnt});
        end
        skip_l2 = 1'b0;

        // late joiner
        step(4'b0001, 4'b0000, 0, 0); chk_model("late_start");
        step(4'b0000, 4'b0000, 0, 0); chk_model("late_wait");
        step(4'b0100, 4'b0000, 0, 0); chk("late_pm", {36'd0, pending_mask}, 40'h5);
        step(4'b0000, 4'b0001, 0, 0); chk("late_no_l2req", {39'd0, l2_flush_req}, 40'd0);
        chk_model("late_bit0_done");
        step(4'b0000, 4'b0100, 0, 0); chk("late_l2req", {39'd0, l2_flush_req}, 40'd1);
        step(4'b0000, 4'b0000, 1, 0); chk_model("late_done");

        // deferred re-flush
        base = m_count;
        step(4'b0011, 4'b0000, 0, 0); chk_model("defer_start");
        step(4'b0000, 4'b0011, 0, 0); chk_model("defer_l2req");
        step(4'b0010, 4'b0000, 0, 0); chk_model("defer_queue");
        step(4'b0000, 4'b0000, 1, 0);
        chk("defer_reflush", {36'd0, in_flush_mode, flush_done, pending_mask[1:0]}, 40'hE);
        step(4'b0000, 4'b0010, 0, 0); chk_model("defer_l2req2");
        step(4'b0000, 4'b0000, 1, 0); chk_model("defer_done2");
        chk("defer_count", flush_count, base + 32'd2);

        // skip_l2 raised mid-sequence must not suppress the L2 flush
        step(4'b0001, 4'b0000, 0, 0);
        skip_l2 = 1'b1;
        step(4'b0000, 4'b0001, 0, 0); chk("skip_late_l2req", {39'd0, l2_flush_req}, 40'd1);
        step(4'b0000, 4'b0000, 1, 0); chk_model("skip_late_done");
        skip_l2 = 1'b0;

        // watchdog: 8 quiet wait cycles abort
        timeout_cycles = 16'd8;
        base = m_count;
        step(4'b0001, 4'b0000, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            step(4'b0000, 4'b0000, 0, 0);
            chk_model($sformatf("wd_quiet[%0d]", k));
        end
        chk("wd_still_active", {39'd0, in_flush_mode}, 40'd1);
        step(4'b0000, 4'b0000, 0, 0);
        chk("wd_abort", {37'd0, timeout_err, in_flush_mode, flush_done}, 40'h4);
        chk("wd_count_kept", flush_count, base);
        // a new timeout wins over a same-cycle clear, and errors do not block new sequences
        step(4'b0001, 4'b0000, 0, 0); chk("wd_new_seq", {39'd0, in_flush_mode}, 40'd1);
        for (int k = 1; k <= 7; k++) step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0000, 0, 1); chk("wd_set_wins", {39'd0, timeout_err}, 40'd1);
        step(4'b0000, 4'b0000, 0, 1); chk("wd_clear", {39'd0, timeout_err}, 40'd0);
        // progress on the 7th wait cycle restarts the count
        step(4'b0011, 4'b0000, 0, 0);
        for (int k = 1; k <= 6; k++) step(4'b0000, 4'b0000, 0, 0);
        step(4'b0000, 4'b0001, 0, 0); chk_model("wd_progress");
        for (int k = 1; k <= 7; k++) step(4'b0000, 4'b0000, 0, 0);
        chk("wd_restarted", {38'd0, timeout_err, in_flush_mode}, 40'd1);
        step(4'b0000, 4'b0000, 0, 0);
        chk("wd_abort2", {38'd0, timeout_err, in_flush_mode}, 40'd2);
        step(4'b0000, 4'b0000, 0, 1); chk_model("wd_clear2");
        timeout_cycles = 16'd0;

        // asynchronous reset while waiting on L2
        step(4'b0001, 4'b0000, 0, 0);
        step(4'b0000, 4'b0001, 0, 0); chk_model("rst_in_l2");
        #2 reset = 1'b1;
        #1 chk("async_reset", dut_vec(), 40'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(4'b0000, 4'b0000, 1, 0);
        chk("rst_no_done", dut_vec(), 40'd0);

        // randomized traffic
        tmo_opts[0] = 16'd0; tmo_opts[1] = 16'd3; tmo_opts[2] = 16'd8; tmo_opts[3] = 16'd20;
        for (int i = 0; i < 2400; i++) begin
            if (i % 300 == 0) timeout_cycles = tmo_opts[$urandom_range(0, 3)];
            skip_l2 = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            c   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            l2c = ($urandom_range(0, 3) == 0);
            ec  = ($urandom_range(0, 15) == 0);
            step(r, c, l2c, ec);
            chk_model("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
